dlf_i2f_sched: RTL and testbench

Round-robin scheduler that shares one pipelined int32-to-DLFloat16 conversion core among `NUM_REQ` requesters. It sits between the integer producers (accumulator drains, DMA staging) and the DLFloat16 consumers. It arbitrates requests and drives the core. Results return on a single tagged response port, through a credit-protected result FIFO that absorbs consumer backpressure.

---
 rtl/dlf_pkg.sv | 20 ++
 rtl/dlf_i2f_core.sv | 33 +++
 rtl/dlf_i2f_sched.sv | 156 +++++++++++++++
 tb/tb_dlf_i2f_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlf_pkg.sv
// Shared DLFloat16 definitions: field widths, exponent bias, packed result type.
package dlf_pkg;

    localparam int DLF_EXP_BIAS = 31;
    localparam int DLF_EXP_W    = 6;
    localparam int DLF_MAN_W    = 9;

    typedef struct packed {
        logic                 sign;
        logic [DLF_EXP_W-1:0] exp;
        logic [DLF_MAN_W-1:0] man;
    } dlf16_t;

    function automatic dlf16_t dlf_zero();
        dlf16_t z;
        z = '0;
        return z;
    endfunction

endpackage

// File: rtl/dlf_i2f_core.sv
// Combinational int32 -> DLFloat16 conversion (truncating, no rounding).
module dlf_i2f_core
    import dlf_pkg::*;
(
    input  logic [31:0] op,
    output dlf16_t      res
);

    logic [31:0]          mag;
    logic [4:0]           lead;
    logic                 norm_unused_hi;
    logic [DLF_MAN_W-1:0] man_bits;
    logic [21:0]          norm_unused_lo;

    always_comb begin
        // -2^31 negates to itself, which is the correct unsigned magnitude
        mag  = op[31] ? (~op + 32'd1) : op;
        lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                lead = 5'(i);
            end
        end
        {norm_unused_hi, man_bits, norm_unused_lo} = mag << (5'd31 - lead);
        res = dlf_zero();
        if (op != 32'd0) begin
            res.sign = op[31];
            res.exp  = {1'b0, lead} + DLF_EXP_W'(DLF_EXP_BIAS);
            res.man  = man_bits;
        end
    end

endmodule

// File: rtl/dlf_i2f_sched.sv
// Round-robin scheduler sharing one int32->DLFloat16 core behind a credit-protected FWFT result FIFO.
// Optional statistics outputs (stat_conv, stat_stall) are enabled by defining DLF_I2F_SCHED_STATS_EN.
module dlf_i2f_sched
    import dlf_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_int,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
`ifdef DLF_I2F_SCHED_STATS_EN
    ,
    output logic [15:0]            stat_conv,
    output logic [15:0]            stat_stall
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]     op_arr [NUM_REQ];
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [CNT_W:0]  occupancy;
    logic            credit_ok;
    logic            accept;
    logic            fifo_pop;

    logic [ID_W-1:0] rr_ptr_reg;
    logic            s1_valid_reg;
    logic [31:0]     s1_op_reg;
    logic [ID_W-1:0] s1_id_reg;
    dlf16_t          s1_res;

    dlf16_t          data_mem [FIFO_DEPTH];
    logic [ID_W-1:0] id_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] fifo_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]    = req_int[32*gi +: 32];
            assign req_ready[gi] = grant_found && (grant_idx == ID_W'(gi)) && credit_ok;
        end
    endgenerate

    // Cyclic search starting just after the last accepted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_found && req_valid[ID_W'((int'(rr_ptr_reg) + i) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(rr_ptr_reg) + i) % NUM_REQ);
            end
        end
    end

    // The in-flight stage-1 item already owns a FIFO slot; a same-cycle pop is not counted
    assign occupancy = {1'b0, fifo_count_reg} + {{CNT_W{1'b0}}, s1_valid_reg};
    assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign accept    = grant_found && credit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= ID_W'(NUM_REQ - 1);
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_id_reg    <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                rr_ptr_reg <= grant_idx;
                s1_op_reg  <= op_arr[grant_idx];
                s1_id_reg  <= grant_idx;
            end
        end
    end

    dlf_i2f_core u_core (
        .op  (s1_op_reg),
        .res (s1_res)
    );

    always_ff @(posedge clk) begin
        if (s1_valid_reg) begin
            data_mem[wr_ptr_reg] <= s1_res;
            id_mem[wr_ptr_reg]   <= s1_id_reg;
        end
    end

    assign rsp_valid = (fifo_count_reg != '0);
    assign fifo_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (s1_valid_reg) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({s1_valid_reg, fifo_pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Outputs read as zero while empty so stale memory never reaches the port
    assign rsp_data = rsp_valid ? data_mem[rd_ptr_reg] : dlf_zero();
    assign rsp_id   = rsp_valid ? id_mem[rd_ptr_reg]   : '0;
    assign busy     = s1_valid_reg || rsp_valid;

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(s1_valid_reg && !fifo_pop && (fifo_count_reg == CNT_W'(FIFO_DEPTH))));

`ifdef DLF_I2F_SCHED_STATS_EN
    logic [15:0] stat_conv_reg;
    logic [15:0] stat_stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conv_reg  <= '0;
            stat_stall_reg <= '0;
        end else begin
            if (accept) begin
                stat_conv_reg <= stat_conv_reg + 16'd1;
            end
            if ((|req_valid) && !accept && (stat_stall_reg != 16'hFFFF)) begin
                stat_stall_reg <= stat_stall_reg + 16'd1;
            end
        end
    end

    assign stat_conv  = stat_conv_reg;
    assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_dlf_i2f_sched.sv
// Bench for dlf_i2f_sched: transaction-level queue model checked every cycle plus directed literal checks.
module tb_dlf_i2f_sched;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_int;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [15:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;
`ifdef DLF_I2F_SCHED_STATS_EN
    logic [15:0]           stat_conv;
    logic [15:0]           stat_stall;
`endif

    dlf_i2f_sched #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_int   (req_int),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef DLF_I2F_SCHED_STATS_EN
        ,
        .stat_conv (stat_conv),
        .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks;
    int passed_checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed_checks++;
        end
    endtask

    // Model: every accepted item sits in one queue (stage 1 + FIFO) until popped.
    typedef struct {
        int          id;
        logic [15:0] data;
        int          vis;
    } exp_t;

    exp_t mq[$];
    int   m_rr;
    int   ec;
    int   m_conv;
    int   m_stall;

    function automatic logic [15:0] model_conv(input logic signed [31:0] x);
        longint a;
        longint m;
        int     e;
        if (x == 0) return 16'h0000;
        a = (x < 0) ? -longint'(x) : longint'(x);
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        if (e >= 9) m = (a >> (e - 9)) & 511;
        else        m = (a << (9 - e)) & 511;
        return {(x < 0) ? 1'b1 : 1'b0, 6'(e + 31), 9'(m)};
    endfunction

    function automatic int model_grant();
        int g;
        g = -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (g < 0 && req_valid[(m_rr + i) % NUM_REQ]) g = (m_rr + i) % NUM_REQ;
        end
        return g;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rr    = NUM_REQ - 1;
        m_conv  = 0;
        m_stall = 0;
    endtask

    task automatic model_edge();
        int   g;
        bit   credit;
        exp_t e;
        if (!rst_n) begin
            model_reset();
        end else begin
            g      = model_grant();
            credit = mq.size() < FIFO_DEPTH;
            if (mq.size() > 0 && mq[0].vis <= ec && rsp_ready) void'(mq.pop_front());
            if (g >= 0 && credit) begin
                e.id   = g;
                e.data = model_conv(req_int[32*g +: 32]);
                e.vis  = ec + 2;
                mq.push_back(e);
                m_rr = g;
                m_conv++;
            end else if (|req_valid) begin
                if (m_stall < 65535) m_stall++;
            end
        end
        ec++;
    endtask

    task automatic check_all();
        int               g;
        logic [NUM_REQ-1:0] exp_ready;
        bit               exp_valid;
        if (!rst_n) model_reset();
        exp_ready = '0;
        g = model_grant();
        if (g >= 0 && mq.size() < FIFO_DEPTH) exp_ready[g] = 1'b1;
        exp_valid = mq.size() > 0 && mq[0].vis <= ec;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(mq.size() > 0));
        if (exp_valid) begin
            chk("rsp_data", 32'(rsp_data), 32'(mq[0].data));
            chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
        end
`ifdef DLF_I2F_SCHED_STATS_EN
        chk("stat_conv", 32'(stat_conv), 32'(m_conv & 16'hFFFF));
        chk("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_one(input logic [31:0] v, input logic [15:0] exp_data);
        req_int[31:0] = v;
        req_valid     = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("latency_e0_valid", 32'(rsp_valid), 32'h0);
        step();
        chk("latency_e1_valid", 32'(rsp_valid), 32'h1);
        chk("value_data", 32'(rsp_data), 32'(exp_data));
        chk("value_id", 32'(rsp_id), 32'h0);
        step();
        chk("after_pop_valid", 32'(rsp_valid), 32'h0);
    endtask

    logic [31:0] sweep_in  [8] = '{32'd1, 32'd0, 32'hFFFFFFFF, 32'd3, 32'd1000,
                                   32'h7FFFFFFF, 32'h80000000, 32'd512};
    logic [15:0] sweep_exp [8] = '{16'h3E00, 16'h0000, 16'hBE00, 16'h4100, 16'h51E8,
                                   16'h7BFF, 16'hFC00, 16'h5000};
    int          rr_seq    [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        int acc;
        logic [NUM_REQ-1:0] one_hot;
        total_checks  = 0;
        passed_checks = 0;
        ec            = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_int   = '0;
        rsp_ready = 1'b1;
        model_reset();

        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Single request then value sweep on requester 0
        for (int i = 0; i < 8; i++) send_one(sweep_in[i], sweep_exp[i]);

        // Round robin with all requesters valid
        for (int k = 0; k < NUM_REQ; k++) req_int[32*k +: 32] = 32'(100 + k);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            one_hot = 4'b0001 << rr_seq[i];
            chk("rr_grant", 32'(req_ready), 32'(one_hot));
            if (i >= 2) chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure on requester 2
        rsp_ready       = 1'b0;
        req_int[95:64]  = 32'h80000000;
        req_valid       = 4'b0100;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req_ready[2]) acc++;
            step();
        end
        chk("bp_accepts", 32'(acc), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'h0);
        rsp_ready = 1'b1;
        chk("bp_head_data", 32'(rsp_data), 32'h0000FC00);
        chk("bp_head_id", 32'(rsp_id), 32'd2);
        step();
        chk("bp_resume", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        repeat (8) step();
        chk("bp_drained_busy", 32'(busy), 32'h0);

        // Reset with three results queued
        rsp_ready     = 1'b0;
        req_int[63:32] = 32'd7;
        req_valid     = 4'b0010;
        repeat (3) step();
        req_valid = '0;
        repeat (2) step();
        chk("mid_queued_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) step();
        chk("mid_no_stale", 32'(rsp_valid), 32'h0);

`ifdef DLF_I2F_SCHED_STATS_EN
        // 10 accepts and 5 stalled cycles from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n         = 1'b1;
        rsp_ready     = 1'b0;
        req_int[31:0] = 32'd42;
        req_valid     = 4'b0001;
        repeat (8) step();
        rsp_ready = 1'b1;
        repeat (7) step();
        req_valid = '0;
        #1;
        chk("stat_conv_lit", 32'(stat_conv), 32'd10);
        chk("stat_stall_lit", 32'(stat_stall), 32'd5);
        repeat (6) step();
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
